core_mem_arb: RTL and testbench

CORE_MEM_ARB -- requirements
Module: core_mem_arb

---
 rtl/core_mem_arb_pkg.sv | 16 +
 rtl/core_mem_arb.sv | 109 ++++++++++
 tb/tb_core_mem_arb.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_arb_pkg.sv
// Shared definitions for the core memory arbiter: read-owner encoding and
// the default fetch-starvation limit.
// Contents: owner_e (NONE/IF/DM), STARVE_LIMIT_DEF.
package core_mem_arb_pkg;

  // Which port receives the read data returned one cycle after a grant.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  // Maximum consecutive data-port grants while a fetch request waits.
  localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/core_mem_arb.sv
// Purpose: arbitrates a fetch port and a data port onto one single-port memory.
// Latency: grant is combinational in the request cycle; read data returns one cycle later.
// Backpressure: a losing request is simply not granted and must be held; the data
//   port wins by default, the fetch port wins after STARVE_LIMIT data grants.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   if_req/if_addr/if_gnt       - fetch request, byte address, accept
//   if_rvalid/if_rdata          - fetch read return
//   dm_req/dm_addr/dm_wen/dm_wdata/dm_gnt - data request (dm_wen=0 is a load), accept
//   dm_rvalid/dm_rdata          - data load return
//   mem_en/mem_addr/mem_wen/mem_wdata/mem_rdata - single-port memory interface
module core_mem_arb
  import core_mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_wen,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  owner_e        owner, owner_nxt;
  logic [CW-1:0] starve_cnt, starve_cnt_nxt;
  logic          fetch_due;

  // Memory words are addressed on 4-byte boundaries; the low address bits
  // carry no information for this block.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], dm_addr[1:0]};

  assign fetch_due = (starve_cnt == LIMIT);

  // Grant and memory command. Fetch wins only when the data port is idle or
  // the fetch port has waited through STARVE_LIMIT data grants.
  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_wen   = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (if_req && (fetch_due || !dm_req)) begin
        if_gnt   = 1'b1;
        mem_en   = 1'b1;
        mem_addr = {if_addr[31:2], 2'b00};
      end else if (dm_req) begin
        dm_gnt    = 1'b1;
        mem_en    = 1'b1;
        mem_addr  = {dm_addr[31:2], 2'b00};
        mem_wen   = dm_wen;
        mem_wdata = dm_wdata;
      end
    end
  end

  // Next owner and starvation count.
  always_comb begin
    owner_nxt      = OWN_NONE;
    starve_cnt_nxt = starve_cnt;
    if (if_gnt || !if_req) begin
      starve_cnt_nxt = '0;
    end else if (dm_gnt && !fetch_due) begin
      starve_cnt_nxt = starve_cnt + CW'(1);
    end
    if (if_gnt) begin
      owner_nxt = OWN_IF;
    end else if (dm_gnt && (dm_wen == 4'b0000)) begin
      owner_nxt = OWN_DM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      owner      <= owner_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Returns are suppressed while rst is high so a read granted just before
  // reset never surfaces.
  assign if_rvalid = !rst && (owner == OWN_IF);
  assign dm_rvalid = !rst && (owner == OWN_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_core_mem_arb.sv
module tb_core_mem_arb;
  import core_mem_arb_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_wen;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wen;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem    [0:255];
  logic [31:0] shadow [0:255];

  core_mem_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_wen(dm_wen), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  // Memory behind the arbiter: one-cycle read latency, junk when no read.
  initial for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
  always @(posedge clk) begin
    if (mem_en && mem_wen == 4'b0000) mem_rdata <= mem[mem_addr[9:2]];
    else mem_rdata <= $urandom;
    if (mem_en)
      for (int b = 0; b < 4; b++)
        if (mem_wen[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr,
                        input logic [31:0] da, input logic [3:0] dw, input logic [31:0] dd);
    if_req = ir; if_addr = ia; dm_req = dr; dm_addr = da; dm_wen = dw; dm_wdata = dd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1, 32'h100, 1, 32'h200, 4'b0000, 32'h0);
    #1;
    checks++;
    if ({if_gnt, dm_gnt, mem_en} !== 3'b000) begin
      failures++; $display("FAIL reset_gnt got=%b exp=000", {if_gnt, dm_gnt, mem_en});
    end
    @(negedge clk);
    #1;
    checks++;
    if ({if_rvalid, dm_rvalid} !== 2'b00 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rvalid got=%b/%h/%h exp=00/0/0", {if_rvalid, dm_rvalid}, if_rdata, dm_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    set_in(0, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
    #1;
    checks++;
    if ({mem_en, mem_wen, mem_addr, mem_wdata} !== 69'h0 || {if_gnt, dm_gnt} !== 2'b00) begin
      failures++; $display("FAIL idle_mem got en=%b addr=%h wen=%b wd=%h exp=all zero", mem_en, mem_addr, mem_wen, mem_wdata);
    end
    @(negedge clk);
  endtask

  task automatic test_fetch_only();
    set_in(1, 32'h100, 0, 32'h0, 4'b0000, 32'h0);
    #1;
    checks++;
    if ({if_gnt, dm_gnt, mem_en} !== 3'b101 || mem_addr !== 32'h100 || {mem_wen, mem_wdata} !== 36'h0) begin
      failures++; $display("FAIL fetch_gnt got=%b addr=%h exp=101 addr=00000100", {if_gnt, dm_gnt, mem_en}, mem_addr);
    end
    @(negedge clk);
    set_in(0, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
    #1;
    checks++;
    if ({if_rvalid, dm_rvalid} !== 2'b10 || if_rdata !== init_word(64) || dm_rdata !== 32'h0) begin
      failures++; $display("FAIL fetch_rdata got=%b/%h exp=10/%h", {if_rvalid, dm_rvalid}, if_rdata, init_word(64));
    end
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    set_in(1, 32'h104, 1, 32'h200, 4'b0000, 32'h0);
    #1;
    checks++;
    if ({if_gnt, dm_gnt} !== 2'b01 || mem_addr !== 32'h200) begin
      failures++; $display("FAIL simul_dm_wins got=%b addr=%h exp=01 addr=00000200", {if_gnt, dm_gnt}, mem_addr);
    end
    @(negedge clk);
    set_in(1, 32'h104, 0, 32'h0, 4'b0000, 32'h0);
    #1;
    checks++;
    if ({if_gnt, dm_gnt} !== 2'b10 || mem_addr !== 32'h104 || dm_rvalid !== 1'b1 || dm_rdata !== init_word(128)) begin
      failures++; $display("FAIL simul_if_next got=%b addr=%h dv=%b dd=%h exp=10 00000104 1 %h",
                           {if_gnt, dm_gnt}, mem_addr, dm_rvalid, dm_rdata, init_word(128));
    end
    @(negedge clk);
    set_in(0, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
    #1;
    checks++;
    if ({if_rvalid, dm_rvalid} !== 2'b10 || if_rdata !== init_word(65) || dm_rdata !== 32'h0) begin
      failures++; $display("FAIL simul_if_rdata got=%b/%h exp=10/%h", {if_rvalid, dm_rvalid}, if_rdata, init_word(65));
    end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    int dm_n = 0;
    logic if_pend = 1'b1;
    int prev_own = 0;
    logic [31:0] prev_data = 32'h0;
    logic exp_if;
    for (int c = 1; c <= 8; c++) begin
      set_in(if_pend, 32'h108, (dm_n < 6), 32'h300 + 32'(dm_n) * 4, 4'b0000, 32'hDEAD_BEEF);
      #1;
      exp_if = (c == 5);
      if (c <= 7) begin
        checks++;
        if ({if_gnt, dm_gnt} !== {exp_if, !exp_if}) begin
          failures++; $display("FAIL starve_gnt cycle=%0d got=%b exp=%b", c, {if_gnt, dm_gnt}, {exp_if, !exp_if});
        end
      end
      if (c == 5) begin
        checks++;
        if (mem_addr !== 32'h108 || mem_wen !== 4'b0 || mem_wdata !== 32'h0) begin
          failures++; $display("FAIL starve_fetch_cmd got addr=%h wen=%b wd=%h exp=00000108 0000 00000000", mem_addr, mem_wen, mem_wdata);
        end
      end
      if (prev_own != 0) begin
        checks++;
        if ({if_rvalid, dm_rvalid} !== ((prev_own == 1) ? 2'b10 : 2'b01) ||
            ((prev_own == 1) ? if_rdata : dm_rdata) !== prev_data) begin
          failures++; $display("FAIL starve_return cycle=%0d got=%b/%h/%h exp_owner=%0d data=%h",
                               c, {if_rvalid, dm_rvalid}, if_rdata, dm_rdata, prev_own, prev_data);
        end
      end
      if (exp_if) begin
        prev_own = 1; prev_data = init_word(66); if_pend = 1'b0;
      end else if (dm_n < 6) begin
        prev_own = 2; prev_data = init_word(192 + dm_n); dm_n++;
      end else begin
        prev_own = 0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store();
    logic [31:0] merged;
    merged = (init_word(128) & 32'hFF00_FFFF) | 32'h00AB_0000;
    set_in(0, 32'h0, 1, 32'h203, 4'b0100, 32'h00AB_0000);
    #1;
    checks++;
    if (dm_gnt !== 1'b1 || mem_wen !== 4'b0100 || mem_addr !== 32'h200 || mem_wdata !== 32'h00AB_0000) begin
      failures++; $display("FAIL store_cmd got g=%b wen=%b addr=%h wd=%h exp=1 0100 00000200 00ab0000", dm_gnt, mem_wen, mem_addr, mem_wdata);
    end
    @(negedge clk);
    set_in(0, 32'h0, 1, 32'h200, 4'b0000, 32'h0);
    #1;
    checks++;
    if ({if_rvalid, dm_rvalid} !== 2'b00 || dm_rdata !== 32'h0) begin
      failures++; $display("FAIL store_no_rvalid got=%b/%h exp=00/0", {if_rvalid, dm_rvalid}, dm_rdata);
    end
    @(negedge clk);
    set_in(0, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
    #1;
    checks++;
    if (dm_rvalid !== 1'b1 || dm_rdata !== merged) begin
      failures++; $display("FAIL store_readback got=%b/%h exp=1/%h", dm_rvalid, dm_rdata, merged);
    end
    @(negedge clk);
  endtask

  task automatic test_pipelined();
    int          port [4] = '{1, 2, 1, 2};
    logic [31:0] addr [4] = '{32'h10, 32'h20, 32'h14, 32'h24};
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) set_in(port[k] == 1, addr[k], port[k] == 2, addr[k], 4'b0000, 32'h0);
      else       set_in(0, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
      #1;
      if (k < 4) begin
        checks++;
        if ({if_gnt, dm_gnt} !== ((port[k] == 1) ? 2'b10 : 2'b01) || mem_addr !== addr[k]) begin
          failures++; $display("FAIL pipe_gnt k=%0d got=%b addr=%h exp_port=%0d addr=%h", k, {if_gnt, dm_gnt}, mem_addr, port[k], addr[k]);
        end
      end
      if (k > 0) begin
        checks++;
        if ({if_rvalid, dm_rvalid} !== ((port[k-1] == 1) ? 2'b10 : 2'b01) ||
            ((port[k-1] == 1) ? if_rdata : dm_rdata) !== init_word(int'(addr[k-1] >> 2))) begin
          failures++; $display("FAIL pipe_return k=%0d got=%b/%h/%h exp_port=%0d data=%h", k,
                               {if_rvalid, dm_rvalid}, if_rdata, dm_rdata, port[k-1], init_word(int'(addr[k-1] >> 2)));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_read();
    set_in(1, 32'h40, 0, 32'h0, 4'b0000, 32'h0);
    #1;
    checks++;
    if (if_gnt !== 1'b1) begin
      failures++; $display("FAIL rstmid_gnt got=%b exp=1", if_gnt);
    end
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
    #1;
    checks++;
    if ({if_rvalid, dm_rvalid} !== 2'b00 || if_rdata !== 32'h0) begin
      failures++; $display("FAIL rstmid_discard got=%b/%h exp=00/0", {if_rvalid, dm_rvalid}, if_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({if_rvalid, dm_rvalid} !== 2'b00) begin
      failures++; $display("FAIL rstmid_after got=%b exp=00", {if_rvalid, dm_rvalid});
    end
    @(negedge clk);
    // Build up starvation, reset, then confirm the full limit applies again.
    for (int c = 0; c < 3; c++) begin
      set_in(1, 32'h48, 1, 32'h60, 4'b0000, 32'h0);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({if_gnt, dm_gnt, mem_en, dm_rvalid} !== 4'b0000) begin
      failures++; $display("FAIL rstmid_force got=%b exp=0000", {if_gnt, dm_gnt, mem_en, dm_rvalid});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      checks++;
      if ({if_gnt, dm_gnt} !== ((c == 5) ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL rstmid_starve cycle=%0d got=%b exp=%b", c, {if_gnt, dm_gnt}, (c == 5) ? 2'b10 : 2'b01);
      end
      @(negedge clk);
    end
    set_in(0, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_random();
    int starve = 0, pend = 0, win = 0, win_prev = 0;
    logic [31:0] pend_data = 32'h0;
    logic ir = 1'b0, dr = 1'b0, rv;
    logic [31:0] ia = 32'h0, da = 32'h0, dd = 32'h0;
    logic [3:0] dw = 4'h0;
    logic e_ig, e_dg, e_en, e_iv, e_dv;
    logic [31:0] e_addr, e_wd, e_ird, e_drd;
    logic [3:0] e_wen;
    for (int i = 0; i < 128; i++) shadow[i] = init_word(i);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!ir || win_prev == 1 || $urandom_range(0, 9) == 0) begin
        ir = ($urandom_range(0, 2) != 0);
        ia = 32'($urandom_range(0, 511));
      end
      if (!dr || win_prev == 2 || $urandom_range(0, 9) == 0) begin
        dr = ($urandom_range(0, 3) != 0);
        da = 32'($urandom_range(0, 127)) << 2;
        dw = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom_range(1, 15));
        dd = $urandom;
      end
      rv = (cyc == 0) || ($urandom_range(0, 39) == 0);
      if (rv) win = 0;
      else if (ir && (starve == LIMIT || !dr)) win = 1;
      else if (dr) win = 2;
      else win = 0;
      e_ig = (win == 1); e_dg = (win == 2); e_en = (win != 0);
      e_addr = (win == 1) ? (ia & ~32'h3) : (win == 2) ? (da & ~32'h3) : 32'h0;
      e_wen = (win == 2) ? dw : 4'h0;
      e_wd = (win == 2) ? dd : 32'h0;
      e_iv = !rv && pend == 1; e_dv = !rv && pend == 2;
      e_ird = e_iv ? pend_data : 32'h0;
      e_drd = e_dv ? pend_data : 32'h0;
      rst = rv;
      set_in(ir, ia, dr, da, dw, dd);
      #1;
      checks++;
      if ({if_gnt, dm_gnt, mem_en} !== {e_ig, e_dg, e_en}) begin
        failures++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", cyc, {if_gnt, dm_gnt, mem_en}, {e_ig, e_dg, e_en});
      end
      checks++;
      if (mem_addr !== e_addr || mem_wen !== e_wen || mem_wdata !== e_wd) begin
        failures++; $display("FAIL rand_mem cyc=%0d got=%h/%b/%h exp=%h/%b/%h", cyc, mem_addr, mem_wen, mem_wdata, e_addr, e_wen, e_wd);
      end
      checks++;
      if (if_rvalid !== e_iv || if_rdata !== e_ird) begin
        failures++; $display("FAIL rand_if_ret cyc=%0d got=%b/%h exp=%b/%h", cyc, if_rvalid, if_rdata, e_iv, e_ird);
      end
      checks++;
      if (dm_rvalid !== e_dv || dm_rdata !== e_drd) begin
        failures++; $display("FAIL rand_dm_ret cyc=%0d got=%b/%h exp=%b/%h", cyc, dm_rvalid, dm_rdata, e_dv, e_drd);
      end
      if (rv) begin
        starve = 0; pend = 0;
      end else begin
        if (win == 1 || !ir) starve = 0;
        else if (win == 2 && starve < LIMIT) starve++;
        pend = 0;
        if (win == 1) begin
          pend = 1; pend_data = shadow[ia[8:2]];
        end else if (win == 2 && dw == 4'b0000) begin
          pend = 2; pend_data = shadow[da[8:2]];
        end else if (win == 2) begin
          for (int b = 0; b < 4; b++)
            if (dw[b]) shadow[da[8:2]][8*b +: 8] = dd[8*b +: 8];
        end
      end
      win_prev = win;
      @(negedge clk);
    end
    rst = 1'b0;
    set_in(0, 32'h0, 0, 32'h0, 4'b0000, 32'h0);
    #1;
    checks++;
    if (if_rvalid !== (pend == 1) || dm_rvalid !== (pend == 2) ||
        (pend == 1 && if_rdata !== pend_data) || (pend == 2 && dm_rdata !== pend_data)) begin
      failures++; $display("FAIL rand_final got=%b/%h/%h exp_owner=%0d data=%h", {if_rvalid, dm_rvalid}, if_rdata, dm_rdata, pend, pend_data);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_store();
    test_pipelined();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
